// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned BURST_CNT_W   = 4;
  localparam int unsigned GNT_CNT_W     = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of a requester index, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after start, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = IW'((32'(start) + 32'(k)) % N);
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = pos;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port; zero-latency grant.
// Optional per-requester grant counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_full,
  output logic                    fifo_write,
  output logic [WIDTH-1:0]        fifo_data_write
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*GNT_CNT_W-1:0] gnt_cnt
`endif
);

  localparam int unsigned OW = idx_width(NREQ);

  arb_state_t             state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [OW-1:0]          start;
  logic [NREQ-1:0]        pick_oh;
  logic [OW-1:0]          pick_idx;
  logic                   pick_valid;

  // Search begins one past the last owner so every requester gets its turn.
  assign start = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  rr_pick #(
    .N  (NREQ),
    .IW (OW)
  ) u_pick (
    .req    (req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Owner keeps the port while it requests; a dropped owner is replaced in the same cycle.
  always_comb begin
    gnt         = '0;
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!reset && !fifo_full) begin
      if (state_q == BURST && req[owner_q]) begin
        gnt[owner_q] = 1'b1;
        burst_cnt_d  = burst_cnt_q + BURST_CNT_W'(1);
        if (burst_cnt_d == BURST_CNT_W'(MAX_BURST)) begin
          state_d = IDLE;
        end
      end else if (pick_valid) begin
        gnt         = pick_oh;
        owner_d     = pick_idx;
        burst_cnt_d = BURST_CNT_W'(1);
        state_d     = (MAX_BURST == 1) ? IDLE : BURST;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Grant is one-hot or zero, so OR-ing masked slices is a clean data mux.
  always_comb begin
    fifo_write      = |gnt;
    fifo_data_write = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        fifo_data_write = fifo_data_write | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NREQ-1:0][GNT_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i] && (gnt_cnt_q[i] != {GNT_CNT_W{1'b1}})) begin
        gnt_cnt_d[i] = gnt_cnt_q[i] + GNT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt_q <= '0;
    end else begin
      gnt_cnt_q <= gnt_cnt_d;
    end
  end

  assign gnt_cnt = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NREQ=4, WIDTH=32, MAX_BURST=2).
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int MB    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_write;
  logic [WIDTH-1:0]      fifo_data_write;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0]    gnt_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_full       (fifo_full),
    .fifo_write      (fifo_write),
    .fifo_data_write (fifo_data_write)
`ifdef FIFO_ARB_STATS_EN
    ,
    .gnt_cnt         (gnt_cnt)
`endif
  );

  typedef struct packed {
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_state = 0;
  int   m_owner = NREQ - 1;
  int   m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slice_of(input logic [NREQ-1:0] g);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) d = req_data[i*WIDTH +: WIDTH];
    end
    return d;
  endfunction

  // Reference arbiter; advances to the state after this cycle's edge.
  task automatic model_step(input logic [NREQ-1:0] r, input logic f, input logic rs,
                            output logic [NREQ-1:0] g);
    bit found;
    int p;
    g = '0;
    found = 1'b0;
    if (rs) begin
      m_state = 0; m_owner = NREQ - 1; m_cnt = 0;
    end else if (!f) begin
      if (m_state == 1 && r[m_owner]) begin
        g[m_owner] = 1'b1;
        m_cnt++;
        if (m_cnt == MB) m_state = 0;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          p = (m_owner + k) % NREQ;
          if (!found && r[p]) begin
            found = 1'b1; g[p] = 1'b1; m_owner = p; m_cnt = 1;
            m_state = (MB == 1) ? 0 : 1;
          end
        end
        if (!found) m_state = 0;
      end
    end
  endtask

  // One cycle: drive, push expectation, sample mid-cycle, pop and compare.
  task automatic step(input logic [NREQ-1:0] r, input logic f, input logic rs,
                      input logic [NREQ-1:0] want, input bit directed, input string tag);
    logic [NREQ-1:0] mg;
    exp_t e, o;
    req = r; fifo_full = f; reset = rs;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = {8'(i + 1), 24'($urandom)};
    model_step(r, f, rs, mg);
    e.g = directed ? want : mg;
    e.d = slice_of(e.g);
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 64'(1), 64'(0));
    end else begin
      o = sb.pop_front();
      check({tag, " gnt"}, 64'(gnt), 64'(o.g));
      check({tag, " fifo_write"}, 64'(fifo_write), 64'(|o.g));
      check({tag, " data"}, 64'(fifo_data_write), 64'(o.d));
    end
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] ord [0:8];

  initial begin
    reset = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;
    @(posedge clk);
    #1;

    // Reset blocks grants even with every request high; then burst order with MAX_BURST=2.
    step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, "rst_hold");
    step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, "rst_hold2");
    ord = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 9; i++) step(4'b1111, 1'b0, 1'b0, ord[i], 1'b1, $sformatf("order%0d", i));

    // Owner drops mid-burst: next requester granted in the same cycle.
    step(4'b0101, 1'b0, 1'b1, 4'b0000, 1'b1, "drop_rst");
    step(4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, "drop_w0");
    step(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, "drop_w2");

    // Full stalls requester 1's burst; count survives so its second word closes the burst.
    step(4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, "full_rst");
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, "full_w1");
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, $sformatf("full%0d", i));
    step(4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, "full_resume");
    step(4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, "full_after");

    // Reset mid-burst of requester 2 restarts at requester 0.
    step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, "mid_rst0");
    ord = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0, ord[i], 1'b1, $sformatf("mid%0d", i));
    step(4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, "mid_rst");
    step(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, "mid_after");

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom), ($urandom_range(3) == 0), ($urandom_range(40) == 0), 4'b0000, 1'b0, "rand");
    end

`ifdef FIFO_ARB_STATS_EN
    step(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, "st_rst");
    check("cnt_rst", 64'(gnt_cnt), 64'(0));
    for (int i = 0; i < 5; i++) step(4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, $sformatf("st%0d", i));
    check("cnt3_five", 64'(gnt_cnt[48 +: 16]), 64'(5));
    check("cnt0_zero", 64'(gnt_cnt[0 +: 16]), 64'(0));
    req = 4'b1000; fifo_full = 1'b0; reset = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    check("cnt3_sat", 64'(gnt_cnt[48 +: 16]), 64'(16'hFFFF));
    step(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, "st_rst2");
    check("cnt_clr", 64'(gnt_cnt), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
